// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine: substitutes the 16 bytes of a 128-bit
// state through the inverse S-box, BYTES_PER_CYCLE bytes per clock, with
// valid/ready handshakes on both sides.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Only divisors of 16 that are powers of two give a whole number of passes.
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      work_q [16];
    logic [7:0]      work_d [16];
    logic [7:0]      in_bytes [16];
    logic [127:0]    work_flat;
    logic [3:0]      lane_idx [BYTES_PER_CYCLE];
    logic [7:0]      lane_out [BYTES_PER_CYCLE];

    // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Undo the forward affine transform, then take the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte 0 sits in the most significant byte of the 128-bit bus.
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
        assign in_bytes[gi]                 = in_state[127-8*gi -: 8];
        assign work_flat[127-8*gi -: 8]     = work_q[gi];
    end

    // One lookup lane per byte handled in a cycle; lane gi covers byte cnt*B+gi.
    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lanes
        assign lane_idx[gi] = 4'(int'(cnt_q) * BYTES_PER_CYCLE + gi);
        assign lane_out[gi] = inv_sbox(work_q[lane_idx[gi]]);
    end

    // Next-state logic: load on accept, substitute one slice per BUSY cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_bytes;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                    work_d[lane_idx[l]] = lane_out[l];
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_bytes;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and work register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) work_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Handshake outputs decode the state; out_state reads zero unless DONE.
    assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out_state = (state_q == S_DONE) ? work_flat : 128'h0;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: directed vectors, exhaustive byte coverage,
// random traffic with backpressure, back-to-back, reset abort and a
// BYTES_PER_CYCLE sweep, checked by a queue-based scoreboard.
module tb_inv_sub_bytes_iter;

    localparam int N = 4;
    localparam logic [127:0] R0     = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] R0_EXP = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_state = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    bit           rand_bp = 1'b0;

    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .in_state(in_state), .in_valid(in_valid),
        .in_ready(in_ready), .out_state(out_state), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    // Sweep instances: BYTES_PER_CYCLE = 1, 2, 8, 16.
    logic [127:0] sw_in_state = R0;
    logic         sw_in_valid = 1'b0;
    logic         sw_out_ready = 1'b1;
    logic [127:0] sw_out_state [4];
    logic         sw_out_valid [4];
    logic         sw_in_ready  [4];
    logic         sw_busy      [4];
    int           bpc_tab [4] = '{1, 2, 8, 16};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int BPC = (gi < 2) ? (1 << gi) : (1 << (gi + 1));
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC)) u_sw (
            .clk(clk), .rst(rst), .in_state(sw_in_state), .in_valid(sw_in_valid),
            .in_ready(sw_in_ready[gi]), .out_state(sw_out_state[gi]),
            .out_valid(sw_out_valid[gi]), .out_ready(sw_out_ready), .busy(sw_busy[gi])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from its definition (inverse by search, then affine);
    // the inverse table is obtained by inverting that mapping.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_m[sbox_m[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] s);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = isbox_m[s[127-8*j -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = sbox_m[s[127-8*j -: 8]];
        return r;
    endfunction

    // Scoreboard queues: expected output, original input, accept cycle.
    logic [127:0] exp_q [$];
    logic [127:0] src_q [$];
    int           acc_q [$];
    bit           lat_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: output side first, then record any accept about to happen.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            src_q.delete();
            acc_q.delete();
            lat_done = 1'b0;
        end else begin
            if (busy) chk("busy_in_ready", 128'(in_ready), 128'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 128'(out_valid), 128'd0);
                end else begin
                    if (!lat_done) begin
                        chk("latency", 128'(cyc - acc_q[0]), 128'(N));
                        lat_done = 1'b1;
                    end
                    chk("out_state", out_state, exp_q[0]);
                    if (out_ready) begin
                        chk("fwd_roundtrip", fwd_state(out_state), src_q[0]);
                        void'(exp_q.pop_front());
                        void'(src_q.pop_front());
                        void'(acc_q.pop_front());
                        lat_done = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_inv(in_state));
                src_q.push_back(in_state);
                acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic send(input logic [127:0] s);
        int t = 0;
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_state = s;
        in_valid = 1'b1;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_out(input logic [127:0] exp, input string name);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_valid"}, 128'(out_valid), 128'd1);
        chk(name, out_state, exp);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] s;
        int lat [4];
        logic [127:0] st [4];

        build_tables();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Directed vectors
        send(R0);
        wait_out(R0_EXP, "row0");
        send({16{8'h00}});
        wait_out({16{8'h52}}, "all00");
        send({16{8'h63}});
        wait_out({16{8'h00}}, "all63");
        send({16{8'h48}});
        wait_out({16{8'hd4}}, "all48");
        drain();

        // All 256 byte values across 16 states
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) s[127-8*j -: 8] = 8'(16 * k + j);
            send(s);
        end
        drain();

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 24; k++) send(rnd128());
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        // Backpressure hold, then release with no new input
        out_ready = 1'b0;
        s = rnd128();
        send(s);
        wait_out(model_inv(s), "bp_first");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_valid", 128'(out_valid), 128'd0);
        chk("bp_idle_in_ready", 128'(in_ready), 128'd1);

        // Back-to-back: in_valid held high across two states
        begin
            int t = 0;
            bit ok = 1'b0;
            @(posedge clk); #1;
            in_state = rnd128();
            in_valid = 1'b1;
            while (!ok && t < 50) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                t++;
            end
            in_state = rnd128();
            ok = 1'b0;
            t = 0;
            while (!ok && t < 50) begin
                @(negedge clk);
                ok = in_ready;
                t++;
            end
            chk("b2b_same_edge", 128'(out_valid && ok), 128'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("b2b_valid_drop", 128'(out_valid), 128'd0);
            chk("b2b_busy", 128'(busy), 128'd1);
        end
        drain();

        // Reset abort two cycles into BUSY
        send({16{8'h52}});
        @(posedge clk);
        #2;
        chk("abort_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_out_state", out_state, 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send({16{8'h16}});
        wait_out({16{8'hff}}, "after_abort");
        drain();

        // Parameter sweep on the row-0 vector
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1;
            st[i]  = '0;
        end
        @(posedge clk); #1;
        sw_in_valid = 1'b1;
        @(posedge clk); #1;
        sw_in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (sw_out_valid[i] && lat[i] < 0) begin
                    lat[i] = k - 1;
                    st[i]  = sw_out_state[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep_latency_bpc%0d", bpc_tab[i]), 128'(lat[i]), 128'(16 / bpc_tab[i]));
            chk($sformatf("sweep_state_bpc%0d", bpc_tab[i]), st[i], R0_EXP);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
